// File: rtl/f_predict_if.sv
// Fetch/execute-side signal bundle for the f_predict branch predictor.
// The master modport is the pipeline and the slave modport is the predictor.
interface f_predict_if #(
  parameter int PC_W = 13
);
  logic [PC_W-1:0] f_pc;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            e_valid;
  logic [PC_W-1:0] e_pc;
  logic [PC_W-1:0] e_nextpc;
  logic [1:0]      e_jump_code;
  logic            e_fail_predict;
  logic [15:0]     branch_cnt;
  logic [15:0]     mispredict_cnt;

  modport master (
    output f_pc, e_valid, e_pc, e_nextpc, e_jump_code, e_fail_predict,
    input  pred_pc, pred_taken, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  f_pc, e_valid, e_pc, e_nextpc, e_jump_code, e_fail_predict,
    output pred_pc, pred_taken, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/f_predict.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency next-PC lookup
// for fetch, trained by resolved control transfers from the execute stage.
module f_predict #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  f_predict_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  localparam logic [1:0] JC_NONE = 2'b00;
  localparam logic [1:0] JC_COND = 2'b01;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic             jmp_q    [ENTRIES];

  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];
  logic [1:0]       cnt_d    [ENTRIES];
  logic             jmp_d    [ENTRIES];

  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

  // Fetch-side lookup, reads registered contents only (no update bypass)
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [PC_W-1:0]  f_seq;
  logic             f_hit;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;

  assign f_idx = bus.f_pc[IDX_W-1:0];
  assign f_tag = bus.f_pc[PC_W-1:IDX_W];
  assign f_seq = bus.f_pc + PC_W'(1);
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  always_comb begin
    pred_pc    = f_seq;
    pred_taken = 1'b0;
    if (f_hit && (jmp_q[f_idx] || cnt_q[f_idx][1])) begin
      pred_pc    = target_q[f_idx];
      pred_taken = 1'b1;
    end
  end

  assign bus.pred_pc        = pred_pc;
  assign bus.pred_taken     = pred_taken;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // Execute-side training
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             e_taken;
  logic             upd;

  assign e_idx   = bus.e_pc[IDX_W-1:0];
  assign e_tag   = bus.e_pc[PC_W-1:IDX_W];
  assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_taken = (bus.e_nextpc != (bus.e_pc + PC_W'(1)));
  assign upd     = bus.e_valid && (bus.e_jump_code != JC_NONE);

  always_comb begin
    valid_d          = valid_q;
    tag_d            = tag_q;
    target_d         = target_q;
    cnt_d            = cnt_q;
    jmp_d            = jmp_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (upd) begin
      branch_cnt_d = sat_inc16(branch_cnt_q);
      if (bus.e_jump_code == JC_COND) begin
        if (e_hit) begin
          cnt_d[e_idx] = e_taken ? sat_inc2(cnt_q[e_idx]) : sat_dec2(cnt_q[e_idx]);
          jmp_d[e_idx] = 1'b0;
          if (e_taken) target_d[e_idx] = bus.e_nextpc;
        end else if (e_taken) begin
          valid_d[e_idx]  = 1'b1;
          tag_d[e_idx]    = e_tag;
          target_d[e_idx] = bus.e_nextpc;
          cnt_d[e_idx]    = 2'b10;
          jmp_d[e_idx]    = 1'b0;
        end
      end else begin
        // jal/jalr always (re)allocate as an unconditional redirect
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = bus.e_nextpc;
        cnt_d[e_idx]    = 2'b11;
        jmp_d[e_idx]    = 1'b1;
      end
    end

    if (bus.e_valid && bus.e_fail_predict)
      mispredict_cnt_d = sat_inc16(mispredict_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      target_q         <= target_d;
      cnt_q            <= cnt_d;
      jmp_q            <= jmp_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
endmodule

// File: doc/f_predict.md
# f_predict

Fetch-stage branch predictor. It supplies the predicted next PC for the instruction being fetched, and it learns from control-transfer outcomes resolved in the execute stage (resolved next PC, jump code, mispredict flag). The block is a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry, plus two saturating performance counters. PCs are 13-bit word addresses.

## Interface
- IDX_W, 4, index width; the table has 2^IDX_W entries
- PC_W, 13, PC width in words; tag width is PC_W-IDX_W
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_pc  in  PC_W  PC of the instruction being fetched
- pred_pc  out  PC_W  predicted next PC for f_pc
- pred_taken  out  1  prediction is a redirect (pred_pc != f_pc+1)
- e_valid  in  1  E stage holds a valid instruction this cycle
- e_pc  in  PC_W  PC of the E-stage instruction
- e_nextpc  in  PC_W  resolved next PC
- e_jump_code  in  2  00 none, 01 cond branch, 10 jal, 11 jalr
- e_fail_predict  in  1  E-stage mispredict indication
- branch_cnt  out  16  resolved control transfers (saturating)
- mispredict_cnt  out  16  mispredicts (saturating)

## Operation
- Each entry holds: valid, tag[PC_W-IDX_W], target[PC_W], cnt[2], jmp (1 means jal/jalr).
- Lookup (combinational): idx=f_pc[IDX_W-1:0], tag=f_pc[PC_W-1:IDX_W]; hit = valid & tag match.
- If hit & (jmp | cnt[1]): pred_pc=target, pred_taken=1. Otherwise pred_pc=f_pc+1 (mod 2^PC_W, so 0x1FFF wraps to 0x0000) and pred_taken=0.
- Update when e_valid & e_jump_code!=00. Index and tag come from e_pc. taken = (e_nextpc != e_pc+1), using the same modular add.
- Cond branch, entry hit: cnt increments if taken, decrements if not, saturating at 11/00. target<=e_nextpc only if taken. jmp<=0.
- Cond branch, miss, taken: allocate (overwrite) with valid=1, tag, target=e_nextpc, cnt=10, jmp=0.
- Cond branch, miss, not taken: no write.
- jal/jalr (hit or miss): write valid=1, tag, target=e_nextpc, cnt=11, jmp=1.
- e_jump_code=00, or e_valid=0: no table write and no counter change.
- branch_cnt increments on each update event. mispredict_cnt increments on e_valid & e_fail_predict. Both hold at 0xFFFF.
- A branch whose taken target equals e_pc+1 is treated as not taken.

## Timing
- Lookup has zero latency: pred_pc/pred_taken settle in the same cycle as f_pc.
- Table and counter writes occur on the rising clk edge. They become visible to lookup from the following cycle.
- Same cycle, same index for lookup and update: the lookup uses the pre-update contents (no bypass).
- Reset, asserted at any time including mid-update: takes effect immediately. All valid=0, cnt=01, target=0, tag=0, jmp=0, branch_cnt=0, mispredict_cnt=0.
- During and after reset, outputs are pred_pc=f_pc+1 and pred_taken=0.
- A write in flight at the edge coincident with reset assertion is discarded.
- Release of rst_n is synchronized externally. The first update is accepted on the first rising edge with rst_n=1.

## Test plan
- Reset, then f_pc=0x0010 -> pred_pc=0x0011, pred_taken=0, both counters 0.
- Taken branch: e_pc=0x0010, jump_code=01, e_nextpc=0x0040 -> next cycle f_pc=0x0010 gives pred_pc=0x0040, pred_taken=1 (cnt=10), branch_cnt=1.
- Hysteresis on the same entry:
  - one not-taken (cnt 01) -> pred_pc=0x0011;
  - two taken (cnt 11), then one not-taken (cnt 10) -> still predicts 0x0040.
- Alias: jal at e_pc=0x0020 to 0x0100, with IDX_W=4 so index matches 0x0010 -> f_pc=0x0010 misses (tag mismatch), pred_pc=0x0011; f_pc=0x0020 predicts 0x0100.
- Same-cycle case: update (e_pc=0x0030 taken to 0x0050) with f_pc=0x0030 in the same cycle -> that cycle pred_pc=0x0031, next cycle 0x0050. Wrap: f_pc=0x1FFF on a miss -> pred_pc=0x0000.
- Saturation and reset:
  - force 70000 updates with e_fail_predict=1 -> both counters read 0xFFFF;
  - assert rst_n=0 mid-stream -> counters 0 and all lookups miss immediately.
